// File: rtl/pc_sequencer.sv
// Fetch-stage program counter sequencer: picks the next PC from increment, branch
// redirect, stall, memory wait and halt; counts memory-wait cycles for debug.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush_valid,
  input  logic [15:0] flush_target,
  input  logic        halt,
  input  logic        imem_ready,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        fetch_valid,
  output logic        halted,
  output logic [15:0] wait_cycles
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;
  localparam logic [1:0] HALTED   = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [15:0] pc_nxt;
  logic [15:0] redir, redir_nxt;
  logic [15:0] target;
  logic        pc_we;

  assign target      = {flush_target[15:1], 1'b0};
  assign pc_plus2    = pc + PC_INC;
  assign halted      = (state == HALTED);
  assign fetch_valid = ((state == RUN) || (state == WAIT_MEM)) && imem_ready &&
                       !stall && !flush_valid && !halt;
  assign pc_we       = (pc_nxt != pc);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    redir_nxt = redir;
    case (state)
      RUN: begin
        if (flush_valid)      pc_nxt = target;
        else if (!imem_ready) state_nxt = WAIT_MEM;
        else if (halt)        state_nxt = HALTED;
        else if (!stall)      pc_nxt = pc_plus2;
      end
      WAIT_MEM: begin
        // The fetch address must stay put while the access is outstanding,
        // so a flush here is parked in the redirect register instead.
        if (flush_valid && !imem_ready) begin
          redir_nxt = target;
          state_nxt = REDIRECT;
        end else if (flush_valid) begin
          pc_nxt    = target;
          state_nxt = RUN;
        end else if (imem_ready) begin
          if (halt)        state_nxt = HALTED;
          else begin
            state_nxt = RUN;
            if (!stall) pc_nxt = pc_plus2;
          end
        end
      end
      REDIRECT: begin
        if (flush_valid) redir_nxt = target;
        if (imem_ready) begin
          pc_nxt    = flush_valid ? target : redir;
          state_nxt = RUN;
        end
      end
      default: begin
        if (flush_valid) begin
          pc_nxt    = target;
          state_nxt = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      redir       <= '0;
      wait_cycles <= '0;
    end else begin
      state <= state_nxt;
      redir <= redir_nxt;
      if (pc_we) pc <= pc_nxt;
      if ((state == WAIT_MEM) && (wait_cycles != 16'hFFFF))
        wait_cycles <= wait_cycles + 16'd1;
    end
  end

endmodule
